// File: rtl/led_pattern_gen_if.sv
// Control and LED bundle for led_pattern_gen.
// Master drives run/mode/divisor; slave returns the LED bank and step pulse.
interface led_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] q;
    logic             step;

    modport master (
        output en,
        output mode,
        output div,
        input  q,
        input  step
    );

    modport slave (
        input  en,
        input  mode,
        input  div,
        output q,
        output step
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: alternate, rotate, bounce, bar fill, blink.
// All outputs are flops; a mode change reloads the seed and restarts the prescaler.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic              clk,
    input  logic              rs,
    led_pattern_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        M_ALT    = 3'b000,
        M_SHL    = 3'b001,
        M_SHR    = 3'b010,
        M_BOUNCE = 3'b011,
        M_FILL   = 3'b100,
        M_BLINK  = 3'b101,
        M_RSV6   = 3'b110,
        M_RSV7   = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALT_SEED = {(WIDTH/2){2'b10}};
    localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] q_q, q_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;

    logic  load;
    logic  tick;
    mode_e mode_in;

    assign mode_in = mode_e'(bus.mode);
    assign load    = (mode_in != mode_q);
    assign tick    = !load && bus.en && (cnt_q >= bus.div);

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        step_d = 1'b0;

        if (load) begin
            mode_d = mode_in;
            cnt_d  = '0;
            dir_d  = 1'b0;
            case (mode_in)
                M_ALT:                  q_d = ALT_SEED;
                M_SHL, M_SHR, M_BOUNCE: q_d = ONE_HOT0;
                M_FILL, M_BLINK:        q_d = ZERO;
                default:                q_d = q_q;
            endcase
        end else if (bus.en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            if (tick) begin
                step_d = 1'b1;
                case (mode_q)
                    M_ALT: q_d = ~q_q;
                    M_SHL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    M_SHR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                    M_BOUNCE: begin
                        // An empty bank would never move again; reseed it.
                        if (q_q == ZERO) begin
                            q_d = ONE_HOT0;
                        end else if (!dir_q) begin
                            if (q_q[WIDTH-1]) begin
                                q_d   = q_q >> 1;
                                dir_d = 1'b1;
                            end else begin
                                q_d = q_q << 1;
                            end
                        end else begin
                            if (q_q[0]) begin
                                q_d   = q_q << 1;
                                dir_d = 1'b0;
                            end else begin
                                q_d = q_q >> 1;
                            end
                        end
                    end
                    M_FILL: begin
                        if (q_q == ALL_ONES) q_d = ZERO;
                        else                 q_d = {q_q[WIDTH-2:0], 1'b1};
                    end
                    M_BLINK: begin
                        if (q_q == ALL_ONES) q_d = ZERO;
                        else                 q_d = ALL_ONES;
                    end
                    default: begin
                        q_d    = q_q;
                        step_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            q_q    <= ALT_SEED;
            cnt_q  <= '0;
            mode_q <= M_ALT;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (WIDTH=8, DIV_W=4).
// Expected values are hand-computed constants and small local tables.
module tb_led_pattern_gen;

    localparam int WIDTH = 8;
    localparam int DIV_W = 4;

    logic clk = 1'b0;
    logic rs;
    int   n_chk = 0;
    int   n_err = 0;

    led_pattern_gen_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    led_pattern_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_qs(input string tag, input logic [7:0] eq,
                          input logic es);
        chk({tag, "_q"}, bus.q, eq);
        chk({tag, "_step"}, bus.step, es);
    endtask

    logic [7:0] bounce_tab [15];
    logic [7:0] fill_tab [9];
    logic [7:0] e;

    initial begin
        bounce_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                       8'h02};
        fill_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                     8'hFF, 8'h00};

        rs       = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 3'b000;
        bus.div  = 4'd0;
        edge1();
        chk_qs("reset", 8'hAA, 1'b0);

        // Original toggle behaviour at div = 0
        rs = 1'b0;
        edge1(); chk_qs("alt1", 8'h55, 1'b1);
        edge1(); chk_qs("alt2", 8'hAA, 1'b1);
        edge1(); chk_qs("alt3", 8'h55, 1'b1);

        // Rotate left, step every 3 cycles
        bus.mode = 3'b001;
        bus.div  = 4'd2;
        edge1(); chk_qs("shl_load", 8'h01, 1'b0);
        e = 8'h01;
        for (int k = 0; k < 8; k++) begin
            edge1(); chk_qs("shl_wait", e, 1'b0);
            edge1(); chk_qs("shl_wait", e, 1'b0);
            e = {e[6:0], e[7]};
            edge1(); chk_qs("shl_step", e, 1'b1);
        end
        chk("shl_wrap", bus.q, 8'h01);

        // Bounce, period 14
        bus.mode = 3'b011;
        bus.div  = 4'd0;
        edge1(); chk_qs("bnc_load", 8'h01, 1'b0);
        for (int k = 0; k < 15; k++) begin
            edge1(); chk_qs("bnc", bounce_tab[k], 1'b1);
        end

        // Bar fill then blink
        bus.mode = 3'b100;
        edge1(); chk_qs("fill_load", 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            edge1(); chk_qs("fill", fill_tab[k], 1'b1);
        end
        bus.mode = 3'b101;
        edge1(); chk_qs("blink_load", 8'h00, 1'b0);
        edge1(); chk_qs("blink1", 8'hFF, 1'b1);
        edge1(); chk_qs("blink2", 8'h00, 1'b1);
        edge1(); chk_qs("blink3", 8'hFF, 1'b1);

        // Enable stall with div = 3
        bus.mode = 3'b000;
        bus.div  = 4'd3;
        edge1(); chk_qs("stall_load", 8'hAA, 1'b0);
        for (int k = 0; k < 3; k++) begin
            edge1(); chk_qs("stall_pre", 8'hAA, 1'b0);
        end
        edge1(); chk_qs("stall_t1", 8'h55, 1'b1);
        edge1(); chk_qs("stall_c1", 8'h55, 1'b0);
        edge1(); chk_qs("stall_c2", 8'h55, 1'b0);
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            edge1(); chk_qs("stall_off", 8'h55, 1'b0);
        end
        bus.en = 1'b1;
        edge1(); chk_qs("stall_c3", 8'h55, 1'b0);
        edge1(); chk_qs("stall_t2", 8'hAA, 1'b1);

        // Lower div under a running count
        bus.div = 4'd7;
        for (int k = 0; k < 5; k++) begin
            edge1(); chk_qs("div7", 8'hAA, 1'b0);
        end
        bus.div = 4'd1;
        edge1(); chk_qs("div_drop", 8'h55, 1'b1);

        // Reserved mode holds
        bus.mode = 3'b110;
        bus.div  = 4'd0;
        edge1(); chk_qs("rsv_load", 8'h55, 1'b0);
        for (int k = 0; k < 4; k++) begin
            edge1(); chk_qs("rsv_hold", 8'h55, 1'b0);
        end

        // Reset mid-bounce, then prescaler restarts from zero
        bus.mode = 3'b011;
        edge1(); chk_qs("rb_load", 8'h01, 1'b0);
        edge1(); chk_qs("rb_1", 8'h02, 1'b1);
        edge1(); chk_qs("rb_2", 8'h04, 1'b1);
        rs       = 1'b1;
        bus.mode = 3'b000;
        bus.div  = 4'd2;
        edge1(); chk_qs("rb_rst", 8'hAA, 1'b0);
        rs = 1'b0;
        edge1(); chk_qs("rb_c1", 8'hAA, 1'b0);
        edge1(); chk_qs("rb_c2", 8'hAA, 1'b0);
        edge1(); chk_qs("rb_tick", 8'h55, 1'b1);

        // Release reset with non-zero mode -> load on next edge
        rs       = 1'b1;
        bus.mode = 3'b011;
        edge1(); chk_qs("rl_rst", 8'hAA, 1'b0);
        rs = 1'b0;
        edge1(); chk_qs("rl_load", 8'h01, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
